wsram_loader: RTL and testbench

- Fills the weight SRAM banks (SRAM_NUM single-port 32x72 macros; shared active-low CEN, per-bank active-low WEN) from a byte stream of 8-bit weights.
- Upstream is the weight DMA/stream interface; downstream is the wsram bank array, whose CEN/WEN/A/D buses this block drives directly.
- Packs 9 weights (one 3x3 kernel) into a 72-bit word. Kernels are distributed round-robin across banks.

---
 rtl/wsram_loader_pkg.sv | 27 ++
 rtl/wsram_loader_if.sv | 37 +++
 rtl/wsram_loader_pack.sv | 48 ++++
 rtl/wsram_loader.sv | 143 ++++++++++++++
 tb/tb_wsram_loader.sv | 299 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/wsram_loader_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | wgt_pkg                                                            |
// | Shared widths, FSM encoding and kernel-count width helper.         |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
package wgt_pkg;

    localparam int WGT_W  = 8;
    localparam int KSIZE  = 9;
    localparam int WORD_W = WGT_W * KSIZE;
    localparam int ADDR_W = 5;
    localparam int DEPTH  = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    function automatic int cnt_w(input int sram_num);
        return $clog2(sram_num * DEPTH) + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/wsram_loader_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | wsram_loader_if                                                    |
// | Weight stream in, bank-array CEN/WEN/A/D out, plus status.         |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
interface wsram_loader_if #(
    parameter int SRAM_NUM = 8
);
    import wgt_pkg::*;

    localparam int CNT_W = cnt_w(SRAM_NUM);

    logic                         start;
    logic [CNT_W-1:0]             num_kernels;
    logic                         in_valid;
    logic                         in_ready;
    logic [WGT_W-1:0]             in_data;
    logic                         CEN;
    logic [SRAM_NUM-1:0]          WEN;
    logic [SRAM_NUM*ADDR_W-1:0]   A;
    logic [SRAM_NUM*WORD_W-1:0]   D;
    logic                         busy;
    logic                         done;

    modport master (
        output start, num_kernels, in_valid, in_data,
        input  in_ready, CEN, WEN, A, D, busy, done
    );

    modport slave (
        input  start, num_kernels, in_valid, in_data,
        output in_ready, CEN, WEN, A, D, busy, done
    );

endinterface
`default_nettype wire

// File: rtl/wsram_loader_pack.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | wgt_pack                                                           |
// | Gathers 9 accepted weight bytes into one 72-bit kernel word.       |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module wgt_pack
    import wgt_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              accept,
    input  logic              clr,
    input  logic [WGT_W-1:0]  in_data,
    output logic              word_valid,
    output logic [WORD_W-1:0] word
);

    localparam int c_IDX_W = $clog2(KSIZE);

    logic [WGT_W*(KSIZE-1)-1:0] r_bytes;
    logic [c_IDX_W-1:0]         r_idx;

    // The final byte is never stored: it is spliced in combinationally so the
    // word is ready on the same edge that accepts it.
    assign word_valid = accept && (r_idx == c_IDX_W'(KSIZE - 1));
    assign word       = {in_data, r_bytes};

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_idx   <= '0;
            r_bytes <= '0;
        end else if (accept) begin
            if (r_idx == c_IDX_W'(KSIZE - 1)) begin
                r_idx <= '0;
            end else begin
                r_idx <= r_idx + c_IDX_W'(1);
                for (int k = 0; k < KSIZE - 1; k++) begin
                    if (r_idx == c_IDX_W'(k)) begin
                        r_bytes[k*WGT_W +: WGT_W] <= in_data;
                    end
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/wsram_loader.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | wsram_loader                                                       |
// | Streams weight bytes into the banked weight SRAM, round-robin.     |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module wsram_loader
    import wgt_pkg::*;
#(
    parameter int SRAM_NUM = 8
)(
    input  logic          clk,
    input  logic          rst,
    wsram_loader_if.slave bus
);

    localparam int c_CNT_W  = cnt_w(SRAM_NUM);
    localparam int c_BANK_W = (SRAM_NUM > 1) ? $clog2(SRAM_NUM) : 1;
    localparam logic [c_CNT_W-1:0] c_CAP = c_CNT_W'(SRAM_NUM * DEPTH);

    state_t                r_state;
    logic                  r_cen;
    logic [SRAM_NUM-1:0]   r_wen;
    logic [ADDR_W-1:0]     r_a;
    logic [WORD_W-1:0]     r_d;
    logic                  r_in_ready;
    logic                  r_busy;
    logic                  r_done;
    logic [c_CNT_W-1:0]    r_num;
    logic [c_CNT_W-1:0]    r_kern_cnt;
    logic [c_BANK_W-1:0]   r_bank;
    logic [ADDR_W-1:0]     r_addr;

    logic                  w_accept;
    logic                  w_clr;
    logic                  w_word_valid;
    logic [WORD_W-1:0]     w_word;
    logic [c_CNT_W-1:0]    w_num_clamped;
    logic [c_CNT_W-1:0]    w_kern_nxt;
    logic [SRAM_NUM-1:0]   w_wen_sel;

    assign w_accept      = bus.in_valid && r_in_ready;
    assign w_clr         = (r_state == ST_IDLE) && bus.start;
    assign w_num_clamped = (bus.num_kernels > c_CAP) ? c_CAP : bus.num_kernels;
    assign w_kern_nxt    = r_kern_cnt + c_CNT_W'(1);

    generate
        for (genvar b = 0; b < SRAM_NUM; b++) begin : g_wen
            assign w_wen_sel[b] = (r_bank != c_BANK_W'(b));
        end
    endgenerate

    wgt_pack u_pack (
        .clk        (clk),
        .rst        (rst),
        .accept     (w_accept),
        .clr        (w_clr),
        .in_data    (bus.in_data),
        .word_valid (w_word_valid),
        .word       (w_word)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_cen      <= 1'b1;
            r_wen      <= '1;
            r_a        <= '0;
            r_d        <= '0;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_num      <= '0;
            r_kern_cnt <= '0;
            r_bank     <= '0;
            r_addr     <= '0;
        end else begin
            // Strobes default inactive; a write only lasts one cycle.
            r_cen  <= 1'b1;
            r_wen  <= '1;
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (bus.start) begin
                        r_num      <= w_num_clamped;
                        r_kern_cnt <= '0;
                        r_bank     <= '0;
                        r_addr     <= '0;
                        if (w_num_clamped == '0) begin
                            r_state <= ST_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state    <= ST_LOAD;
                            r_in_ready <= 1'b1;
                            r_busy     <= 1'b1;
                        end
                    end
                end
                ST_LOAD: begin
                    if (w_word_valid) begin
                        r_cen      <= 1'b0;
                        r_wen      <= w_wen_sel;
                        r_a        <= r_addr;
                        r_d        <= w_word;
                        r_kern_cnt <= w_kern_nxt;
                        // Address steps only when the bank index wraps.
                        if (r_bank == c_BANK_W'(SRAM_NUM - 1)) begin
                            r_bank <= '0;
                            r_addr <= r_addr + ADDR_W'(1);
                        end else begin
                            r_bank <= r_bank + c_BANK_W'(1);
                        end
                        if (w_kern_nxt == r_num) begin
                            r_state    <= ST_FLUSH;
                            r_in_ready <= 1'b0;
                        end
                    end
                end
                ST_FLUSH: begin
                    r_state <= ST_DONE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready = r_in_ready;
    assign bus.CEN      = r_cen;
    assign bus.WEN      = r_wen;
    assign bus.A        = {SRAM_NUM{r_a}};
    assign bus.D        = {SRAM_NUM{r_d}};
    assign bus.busy     = r_busy;
    assign bus.done     = r_done;

endmodule
`default_nettype wire

// File: tb/tb_wsram_loader.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_wsram_loader                                                    |
// | Directed bench with a kernel-level bank model checked every cycle. |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module tb_wsram_loader;

    localparam int S = 8;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    wsram_loader_if #(.SRAM_NUM(S)) bus ();

    wsram_loader #(.SRAM_NUM(S)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [7:0]  wen;
        logic [4:0]  a;
        logic [71:0] d0;
        int          cyc;
    } obs_t;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int last_acc_cyc = 0;
    int done_cyc = 0;
    obs_t obs[$];
    logic [71:0] mem  [S][32];
    logic [71:0] snap [S][32];

    task automatic chk(input string name, input logic [575:0] act, input logic [575:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Kernel-level expectation: every 9th accepted byte yields a write next
    // cycle to bank k%S, address k/S; done two cycles after the final byte.
    bit          m_armed = 0;
    int          m_ph = 0;
    int          m_k = 0;
    int          m_tgt = 0;
    logic [7:0]  m_bytes[$];
    logic        exp_cen, exp_ready, exp_busy, exp_done;
    logic [7:0]  exp_wen;
    logic [4:0]  exp_a;
    logic [71:0] exp_d;

    always @(negedge clk) begin
        cyc++;
        if (m_armed) begin
            chk("cen",      576'(bus.CEN),      576'(exp_cen));
            chk("wen",      576'(bus.WEN),      576'(exp_wen));
            chk("addr",     576'(bus.A),        576'({S{exp_a}}));
            chk("data",     576'(bus.D),        576'({S{exp_d}}));
            chk("in_ready", 576'(bus.in_ready), 576'(exp_ready));
            chk("busy",     576'(bus.busy),     576'(exp_busy));
            chk("done",     576'(bus.done),     576'(exp_done));
        end
        if (bus.CEN === 1'b0) begin
            obs.push_back('{wen: bus.WEN, a: bus.A[4:0], d0: bus.D[71:0], cyc: cyc});
            for (int b = 0; b < S; b++)
                if (bus.WEN[b] === 1'b0) mem[b][bus.A[b*5 +: 5]] = bus.D[b*72 +: 72];
        end
        if (bus.done === 1'b1) done_cyc = cyc;

        if (rst) begin
            m_armed = 1;
            m_ph = 0;
            m_bytes.delete();
            exp_cen = 1'b1; exp_wen = 8'hFF; exp_a = '0; exp_d = '0;
            exp_ready = 1'b0; exp_busy = 1'b0; exp_done = 1'b0;
        end else begin
            exp_cen = 1'b1; exp_wen = 8'hFF; exp_done = 1'b0;
            case (m_ph)
                0: if (bus.start) begin
                    m_tgt = (int'(bus.num_kernels) > S*32) ? S*32 : int'(bus.num_kernels);
                    if (m_tgt == 0) begin
                        m_ph = 3; exp_done = 1'b1;
                    end else begin
                        m_ph = 1; m_k = 0; m_bytes.delete();
                    end
                end
                1: if (bus.in_valid) begin
                    last_acc_cyc = cyc;
                    m_bytes.push_back(bus.in_data);
                    if (m_bytes.size() == 9) begin
                        exp_d = '0;
                        for (int j = 0; j < 9; j++) exp_d[j*8 +: 8] = m_bytes[j];
                        exp_cen = 1'b0;
                        exp_wen = ~(8'(1) << (m_k % S));
                        exp_a   = 5'(m_k / S);
                        m_k++;
                        m_bytes.delete();
                        if (m_k == m_tgt) m_ph = 2;
                    end
                end
                2: begin m_ph = 3; exp_done = 1'b1; end
                default: m_ph = 0;
            endcase
            exp_ready = (m_ph == 1);
            exp_busy  = (m_ph == 1) || (m_ph == 2);
        end
    end

    function automatic logic [7:0] gen(input int kind, input int i);
        case (kind)
            0:       return 8'(i + 1);
            1:       return 8'(i * 7 + 3);
            default: return 8'(161 + i);
        endcase
    endfunction

    // Called at posedge+1; returns at posedge+1.
    task automatic do_start(input int n);
        bus.start = 1'b1;
        bus.num_kernels = 9'(n);
        @(posedge clk); #1;
        bus.start = 1'b0;
    endtask

    task automatic feed(input int nbytes, input int kind, input int pct);
        for (int i = 0; i < nbytes; i++) begin
            bit acc = 0;
            int tries = 0;
            while (!acc) begin
                bus.in_valid = ($urandom_range(0, 99) < pct);
                bus.in_data  = gen(kind, i);
                @(negedge clk);
                acc = bus.in_valid && bus.in_ready;
                @(posedge clk); #1;
                tries++;
                if (tries > 500) begin
                    chk("feed_timeout", 576'(i), 576'(nbytes));
                    bus.in_valid = 1'b0;
                    return;
                end
            end
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_done(input int bound, input string name);
        bit got = 0;
        for (int c = 0; c < bound && !got; c++) begin
            @(negedge clk);
            if (bus.done === 1'b1) got = 1;
        end
        chk(name, 576'(got), 576'(1));
        @(posedge clk); #1;
    endtask

    task automatic clear_mem();
        for (int b = 0; b < S; b++)
            for (int a = 0; a < 32; a++) mem[b][a] = '0;
    endtask

    task automatic check_idle_outputs(input string tag);
        @(negedge clk);
        chk({tag, "_cen"},   576'(bus.CEN),      576'(1'b1));
        chk({tag, "_wen"},   576'(bus.WEN),      576'(8'hFF));
        chk({tag, "_ready"}, 576'(bus.in_ready), 576'(1'b0));
        chk({tag, "_busy"},  576'(bus.busy),     576'(1'b0));
        chk({tag, "_done"},  576'(bus.done),     576'(1'b0));
        @(posedge clk); #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] rr_wen [10];
        logic [4:0] rr_a   [10];
        int s_cyc;
        rr_wen = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F, 8'hFE, 8'hFD};
        rr_a   = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd1, 5'd1};

        rst = 1'b1;
        bus.start = 1'b0; bus.num_kernels = '0; bus.in_valid = 1'b0; bus.in_data = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check_idle_outputs("reset");

        // Single kernel
        obs.delete();
        do_start(1);
        feed(9, 0, 100);
        wait_done(20, "single_done");
        chk("single_nwrites", 576'(obs.size()), 576'(1));
        if (obs.size() >= 1) begin
            chk("single_wen", 576'(obs[0].wen), 576'(8'hFE));
            chk("single_a",   576'(obs[0].a),   576'(5'd0));
            chk("single_d",   576'(obs[0].d0),  576'(72'h090807060504030201));
        end
        chk("single_done_lat", 576'(done_cyc - last_acc_cyc), 576'(2));

        // Round-robin wrap at full rate
        obs.delete();
        clear_mem();
        do_start(10);
        feed(90, 1, 100);
        wait_done(40, "rr_done");
        chk("rr_nwrites", 576'(obs.size()), 576'(10));
        if (obs.size() == 10) begin
            for (int i = 0; i < 10; i++) begin
                chk("rr_wen", 576'(obs[i].wen), 576'(rr_wen[i]));
                chk("rr_a",   576'(obs[i].a),   576'(rr_a[i]));
                if (i > 0) chk("rr_spacing", 576'(obs[i].cyc - obs[i-1].cyc), 576'(9));
            end
        end
        snap = mem;

        // Same stream under backpressure, with a start pulse while busy
        obs.delete();
        clear_mem();
        do_start(10);
        fork
            feed(90, 1, 30);
            begin
                repeat (15) @(posedge clk);
                #1;
                bus.start = 1'b1; bus.num_kernels = 9'd1;
                @(posedge clk); #1;
                bus.start = 1'b0;
            end
        join
        wait_done(40, "bp_done");
        chk("bp_nwrites", 576'(obs.size()), 576'(10));
        for (int i = 0; i < 10; i++)
            chk("bp_mem", 576'(mem[i % S][i / S]), 576'(snap[i % S][i / S]));

        // Zero kernels; start held into the done cycle must be ignored
        obs.delete();
        s_cyc = cyc;
        bus.start = 1'b1; bus.num_kernels = 9'd0;
        @(posedge clk); #1;
        bus.num_kernels = 9'd1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("zero_done_cyc", 576'(done_cyc), 576'(s_cyc + 2));
        chk("zero_nwrites", 576'(obs.size()), 576'(0));
        chk("zero_busy", 576'(bus.busy), 576'(1'b0));

        // Clamp 300 -> 256, excess bytes offered but not taken
        obs.delete();
        do_start(300);
        feed(256 * 9, 1, 100);
        bus.in_valid = 1'b1;
        wait_done(10, "clamp_done");
        check_idle_outputs("clamp_idle");
        bus.in_valid = 1'b0;
        chk("clamp_nwrites", 576'(obs.size()), 576'(256));
        if (obs.size() == 256) begin
            chk("clamp_last_wen", 576'(obs[255].wen), 576'(8'h7F));
            chk("clamp_last_a",   576'(obs[255].a),   576'(5'd31));
        end

        // Abort mid-kernel, then a fresh single-kernel load
        obs.delete();
        do_start(5);
        feed(23, 1, 100);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check_idle_outputs("abort");
        chk("abort_nwrites", 576'(obs.size()), 576'(2));
        do_start(1);
        feed(9, 2, 100);
        wait_done(20, "abort_restart_done");
        chk("restart_nwrites", 576'(obs.size()), 576'(3));
        if (obs.size() == 3) begin
            chk("restart_wen", 576'(obs[2].wen), 576'(8'hFE));
            chk("restart_a",   576'(obs[2].a),   576'(5'd0));
            chk("restart_d",   576'(obs[2].d0),  576'(72'hA9A8A7A6A5A4A3A2A1));
        end

        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
